// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one variable-latency memory between fetch (I) and load/store (D) ports
// Optional: MEMARB_ROUND_ROBIN_EN alternates contended grants instead of fixed D priority.
module mem_port_arbiter #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        m_req,
    output logic        m_we,
    output logic [3:0]  m_be,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    localparam int unsigned   CW       = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

    state_t        r_state, w_next;
    logic          r_owner_d;
    logic          r_m_req, r_m_we;
    logic [3:0]    r_m_be;
    logic [31:0]   r_m_addr, r_m_wdata;
    logic [CW-1:0] r_wait_cnt;
    logic [31:0]   r_i_rdata, r_d_rdata;
    logic          r_i_err, r_d_err;
    logic          w_gnt_i, w_gnt_d, w_timeout, w_done;
`ifdef MEMARB_ROUND_ROBIN_EN
    logic          r_last_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_gnt_i   = 1'b0;
        w_gnt_d   = 1'b0;
        w_timeout = (MAX_WAIT != 0) && (r_wait_cnt == LAST_CNT);
        w_done    = m_ack || w_timeout;
        case (r_state)
            S_IDLE: begin
                if (!reset) begin
`ifdef MEMARB_ROUND_ROBIN_EN
                    if (i_req && d_req) begin
                        w_gnt_i = r_last_d;
                        w_gnt_d = !r_last_d;
                    end else begin
                        w_gnt_i = i_req;
                        w_gnt_d = d_req;
                    end
`else
                    w_gnt_d = d_req;
                    w_gnt_i = i_req && !d_req;
`endif
                end
                if (w_gnt_i || w_gnt_d) w_next = S_BUSY;
            end
            S_BUSY:  if (w_done) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Memory-side request is latched at grant and frozen for the whole BUSY window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner_d  <= 1'b0;
            r_m_req    <= 1'b0;
            r_m_we     <= 1'b0;
            r_m_be     <= 4'h0;
            r_m_addr   <= 32'h0;
            r_m_wdata  <= 32'h0;
            r_wait_cnt <= '0;
            r_i_rdata  <= 32'h0;
            r_d_rdata  <= 32'h0;
            r_i_err    <= 1'b0;
            r_d_err    <= 1'b0;
`ifdef MEMARB_ROUND_ROBIN_EN
            r_last_d   <= 1'b1;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_i || w_gnt_d) begin
                        r_owner_d  <= w_gnt_d;
                        r_m_req    <= 1'b1;
                        r_wait_cnt <= '0;
                        r_m_we     <= w_gnt_d && d_we;
                        r_m_be     <= w_gnt_d ? d_be    : 4'hF;
                        r_m_addr   <= w_gnt_d ? d_addr  : i_addr;
                        r_m_wdata  <= w_gnt_d ? d_wdata : 32'h0;
                    end
                end
                S_BUSY: begin
                    if (w_done) begin
                        r_m_req <= 1'b0;
                        if (r_owner_d) begin
                            r_d_rdata <= (m_ack && !r_m_we) ? m_rdata : 32'h0;
                            r_d_err   <= !m_ack;
                        end else begin
                            r_i_rdata <= m_ack ? m_rdata : 32'h0;
                            r_i_err   <= !m_ack;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_RESP: begin
`ifdef MEMARB_ROUND_ROBIN_EN
                    r_last_d <= r_owner_d;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign i_gnt    = w_gnt_i;
    assign d_gnt    = w_gnt_d;
    assign i_rvalid = (r_state == S_RESP) && !r_owner_d;
    assign d_rvalid = (r_state == S_RESP) && r_owner_d;
    assign i_rdata  = r_i_rdata;
    assign d_rdata  = r_d_rdata;
    assign i_err    = r_i_err;
    assign d_err    = r_d_err;
    assign m_req    = r_m_req;
    assign m_we     = r_m_we;
    assign m_be     = r_m_be;
    assign m_addr   = r_m_addr;
    assign m_wdata  = r_m_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with a word-array reference memory
module tb_mem_port_arbiter;
    localparam int MAXW = 4;

    logic        clk, reset;
    logic        i_req, i_gnt, i_rvalid, i_err;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        m_req, m_we, m_ack;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata, m_rdata;

    mem_port_arbiter #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata)
    );

    typedef struct {logic [31:0] rdata; logic err; int due;} resp_t;
    typedef struct {logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; int lat;} mreq_t;

    int          total = 0, bad = 0;
    int          cyc = 0, outst = 0;
    bit          gi_seen = 0, gd_seen = 0, last_d = 1, rand_on = 0;
    int          force_lat[$];
    resp_t       exp_i[$], exp_d[$];
    mreq_t       mexp[$];
    logic [31:0] ref_mem[16];
    logic [31:0] mem[16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard producer and response checker, both on the falling edge.
    always @(negedge clk) begin : monitor
        resp_t     e;
        mreq_t     q;
        int        lat, hi;
        bit        terr;
        logic [1:0] want;
        if (reset) begin
            outst = 0; exp_i.delete(); exp_d.delete();
            gi_seen = 0; gd_seen = 0; last_d = 1;
        end else begin
            cyc++;
            gi_seen = 0; gd_seen = 0;
            want = 2'b00;
            if (outst == 0) begin
`ifdef MEMARB_ROUND_ROBIN_EN
                if (i_req && d_req) want = last_d ? 2'b10 : 2'b01;
`else
                if (i_req && d_req) want = 2'b01;
`endif
                else want = {i_req, d_req};
            end
            chk("grant", {30'b0, i_gnt, d_gnt}, {30'b0, want});
            if (i_gnt ^ d_gnt) begin
                lat  = (force_lat.size() != 0) ? force_lat.pop_front() : int'($urandom_range(1, MAXW + 2));
                hi   = (lat <= MAXW) ? lat : MAXW;
                terr = (lat > MAXW);
                e.err = terr;
                e.due = cyc + hi + 1;
                if (i_gnt) begin
                    e.rdata = terr ? 32'h0 : ref_mem[i_addr[5:2]];
                    exp_i.push_back(e);
                    q = '{addr: i_addr, we: 1'b0, be: 4'hF, wdata: 32'h0, lat: lat};
                    last_d = 0; gi_seen = 1;
                end else begin
                    e.rdata = (terr || d_we) ? 32'h0 : ref_mem[d_addr[5:2]];
                    if (d_we && !terr)
                        for (int b = 0; b < 4; b++)
                            if (d_be[b]) ref_mem[d_addr[5:2]][8*b +: 8] = d_wdata[8*b +: 8];
                    exp_d.push_back(e);
                    q = '{addr: d_addr, we: d_we, be: d_be, wdata: d_wdata, lat: lat};
                    last_d = 1; gd_seen = 1;
                end
                mexp.push_back(q);
                outst = 1;
            end
            if (i_rvalid && d_rvalid) chk("both_rvalid", 32'd1, 32'd0);
            if (i_rvalid) begin
                if (exp_i.size() == 0) chk("i_unexpected_rvalid", 32'd1, 32'd0);
                else begin
                    e = exp_i.pop_front();
                    chk("i_rdata", i_rdata, e.rdata);
                    chk("i_err", {31'b0, i_err}, {31'b0, e.err});
                    chk("i_latency", cyc, e.due);
                end
                outst = 0;
            end
            if (d_rvalid) begin
                if (exp_d.size() == 0) chk("d_unexpected_rvalid", 32'd1, 32'd0);
                else begin
                    e = exp_d.pop_front();
                    chk("d_rdata", d_rdata, e.rdata);
                    chk("d_err", {31'b0, d_err}, {31'b0, e.err});
                    chk("d_latency", cyc, e.due);
                end
                outst = 0;
            end
        end
    end

    // Memory device: acks on the chosen m_req cycle, throws stray acks while idle.
    always @(negedge clk) begin : responder
        static mreq_t cur = '{addr: 0, we: 0, be: 0, wdata: 0, lat: 1};
        static bit    active = 0;
        static int    n = 0;
        if (reset) begin
            active = 0; m_ack = 1'b0; mexp.delete();
        end else begin
            if (active && !m_req) begin
                chk("mreq_cycles", n, (cur.lat <= MAXW) ? cur.lat : MAXW);
                active = 0;
            end
            if (m_req) begin
                if (!active) begin
                    if (mexp.size() == 0) begin
                        chk("m_req_unexpected", 32'd1, 32'd0);
                        cur = '{addr: m_addr, we: m_we, be: m_be, wdata: m_wdata, lat: 1};
                    end else cur = mexp.pop_front();
                    active = 1; n = 0;
                end
                n++;
                chk("m_addr", m_addr, cur.addr);
                chk("m_we", {31'b0, m_we}, {31'b0, cur.we});
                chk("m_be", {28'b0, m_be}, {28'b0, cur.be});
                chk("m_wdata", m_wdata, cur.wdata);
                m_ack   = (n == cur.lat);
                m_rdata = (m_ack && !m_we) ? mem[m_addr[5:2]] : $urandom;
                if (m_ack && m_we)
                    for (int b = 0; b < 4; b++)
                        if (m_be[b]) mem[m_addr[5:2]][8*b +: 8] = m_wdata[8*b +: 8];
            end else begin
                m_ack   = ($urandom_range(0, 3) == 0);
                m_rdata = $urandom;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (gi_seen) i_req = 1'b0;
        if (gd_seen) d_req = 1'b0;
        if (rand_on && !reset) begin
            if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req = 1'b1; i_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom);
                d_addr = $urandom & 32'hFFFF_FFFC; d_wdata = $urandom;
            end
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((outst != 0 || i_req || d_req) && k < 300) begin tick(); k++; end
        chk("idle_reached", {31'b0, k < 300}, 32'd1);
        repeat (2) tick();
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int k;
        reset = 1'b1; i_req = 0; d_req = 0; d_we = 0; d_be = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0;
        for (int a = 0; a < 16; a++) begin ref_mem[a] = $urandom; mem[a] = ref_mem[a]; end
        ref_mem[0] = 32'h8C22_0004; mem[0] = 32'h8C22_0004;
        repeat (2) tick();
        chk("rst_m_req", {31'b0, m_req}, 0);   chk("rst_m_we", {31'b0, m_we}, 0);
        chk("rst_m_be", {28'b0, m_be}, 0);     chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);        chk("rst_i_gnt", {31'b0, i_gnt}, 0);
        chk("rst_d_gnt", {31'b0, d_gnt}, 0);   chk("rst_i_rvalid", {31'b0, i_rvalid}, 0);
        chk("rst_d_rvalid", {31'b0, d_rvalid}, 0);
        chk("rst_i_rdata", i_rdata, 0);        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_i_err", {31'b0, i_err}, 0);   chk("rst_d_err", {31'b0, d_err}, 0);
        reset = 1'b0;
        repeat (2) tick();

        force_lat.push_back(2); i_req = 1; i_addr = 32'h40; wait_idle();
        force_lat.push_back(1); d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; wait_idle();
        force_lat.push_back(1); d_req = 1; d_we = 0; d_addr = 32'h100; wait_idle();
        force_lat.push_back(2); force_lat.push_back(2);
        i_req = 1; i_addr = 32'h80; d_req = 1; d_we = 0; d_addr = 32'h24; wait_idle();
        force_lat.push_back(MAXW + 3); i_req = 1; i_addr = 32'h8; wait_idle();
        force_lat.push_back(2); d_req = 1; d_we = 0; d_addr = 32'h8; wait_idle();
        force_lat.push_back(MAXW); i_req = 1; i_addr = 32'hC; wait_idle();
        force_lat.push_back(1); d_req = 1; d_we = 1; d_be = 4'h0; d_addr = 32'h14; d_wdata = 32'h1234_5678; wait_idle();
        repeat (8) tick();

        rand_on = 1;
        repeat (800) tick();
        rand_on = 0;
        wait_idle();

        force_lat.push_back(20); i_req = 1; i_addr = 32'h44;
        k = 0;
        while (!m_req && k < 20) begin tick(); k++; end
        tick();
        reset = 1'b1;
        #1;
        chk("midrst_m_req", {31'b0, m_req}, 0);
        chk("midrst_i_rvalid", {31'b0, i_rvalid}, 0);
        chk("midrst_d_rvalid", {31'b0, d_rvalid}, 0);
        repeat (2) tick();
        reset = 1'b0;
        i_req = 0;
        force_lat.push_back(1); i_req = 1; i_addr = 32'h48; wait_idle();

        chk("exp_i_drained", exp_i.size(), 0);
        chk("exp_d_drained", exp_d.size(), 0);
        chk("mexp_drained", mexp.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
